// File: rtl/hazard_scoreboard_if.sv
// Decode-stage operand/hazard bundle between the pipeline and the hazard scoreboard.
// slave = scoreboard side, master = pipeline/driver side.
interface hazard_scoreboard_if #(
  parameter int NRD  = 2,
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_rf;
  logic [AW-1:0]       dstE, dstM;
  logic                validE, validM, ismemE;
  logic [XLEN-1:0]     rdE, rdM;
  logic                issue_mc;
  logic [AW-1:0]       issue_dst;
  logic                mc_done;
  logic [XLEN-1:0]     mc_data;
  logic                flush;
  logic [NRD*XLEN-1:0] rs_fwd;
  logic                stall;
  logic                mc_busy;
  logic [31:0]         stall_cnt;

  modport slave (
    input  rs_addr, rs_rf, dstE, dstM, validE, validM, ismemE, rdE, rdM,
           issue_mc, issue_dst, mc_done, mc_data, flush,
    output rs_fwd, stall, mc_busy, stall_cnt
  );

  modport master (
    output rs_addr, rs_rf, dstE, dstM, validE, validM, ismemE, rdE, rdM,
           issue_mc, issue_dst, mc_done, mc_data, flush,
    input  rs_fwd, stall, mc_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Operand forwarding and hazard detection for decode, tracking one outstanding
// multi-cycle (mul/div) op plus a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int NRD  = 2,
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic clk,
  input  logic reset,
  hazard_scoreboard_if.slave hz
);

  logic          mc_busy_q, mc_busy_d;
  logic [AW-1:0] mc_dst_q, mc_dst_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic [NRD-1:0] port_stall;
  logic          struct_haz, stall, accept;

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_port
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] rf, fwd;
      logic            stl;

      assign addr = hz.rs_addr[g*AW +: AW];
      assign rf   = hz.rs_rf[g*XLEN +: XLEN];

      // First match wins; a stalling port still presents its RF value.
      always_comb begin
        fwd = rf;
        stl = 1'b0;
        if (addr == '0) begin
          fwd = '0;
        end else if (mc_busy_q && addr == mc_dst_q) begin
          if (hz.mc_done) fwd = hz.mc_data;
          else            stl = 1'b1;
        end else if (hz.validE && addr == hz.dstE) begin
          if (hz.ismemE) stl = 1'b1;
          else           fwd = hz.rdE;
        end else if (hz.validM && addr == hz.dstM) begin
          fwd = hz.rdM;
        end
      end

      assign hz.rs_fwd[g*XLEN +: XLEN] = fwd;
      assign port_stall[g]             = stl;
    end
  endgenerate

  // A new mc op cannot start while the previous one is still running,
  // unless it completes this very cycle (back-to-back issue).
  assign struct_haz = hz.issue_mc && mc_busy_q && !hz.mc_done;
  assign stall      = (|port_stall) || struct_haz;
  assign accept     = hz.issue_mc && !stall && !hz.flush;

  always_comb begin
    mc_busy_d   = mc_busy_q;
    mc_dst_d    = mc_dst_q;
    stall_cnt_d = stall_cnt_q;
    if (hz.flush) begin
      mc_busy_d = 1'b0;
    end else if (accept) begin
      mc_busy_d = 1'b1;
      mc_dst_d  = hz.issue_dst;
    end else if (hz.mc_done && mc_busy_q) begin
      mc_busy_d = 1'b0;
    end
    if (stall && !hz.flush && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mc_busy_q   <= 1'b0;
      mc_dst_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      mc_busy_q   <= mc_busy_d;
      mc_dst_q    <= mc_dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall     = stall;
  assign hz.mc_busy   = mc_busy_q;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic checked against a rule-level model.
module tb_hazard_scoreboard;
  localparam int NRD  = 2;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic clk, reset;
  int   n_chk, n_err;

  hazard_scoreboard_if #(.NRD(NRD), .XLEN(XLEN), .AW(AW)) hif ();

  hazard_scoreboard #(.NRD(NRD), .XLEN(XLEN), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic          m_busy;
  logic [AW-1:0] m_dst;
  logic [31:0]   m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hif.rs_addr = '0; hif.rs_rf = '0; hif.dstE = '0; hif.dstM = '0;
    hif.validE = 0; hif.validM = 0; hif.ismemE = 0; hif.rdE = '0; hif.rdM = '0;
    hif.issue_mc = 0; hif.issue_dst = '0; hif.mc_done = 0; hif.mc_data = '0;
    hif.flush = 0;
  endtask

  task automatic model_comb(output logic st, output logic [NRD*XLEN-1:0] f);
    logic [AW-1:0] a;
    logic [XLEN-1:0] v;
    st = hif.issue_mc && m_busy && !hif.mc_done;
    f  = '0;
    for (int p = 0; p < NRD; p++) begin
      a = hif.rs_addr[p*AW +: AW];
      v = hif.rs_rf[p*XLEN +: XLEN];
      if (a == 0) v = '0;
      else if (m_busy && a == m_dst) begin
        if (hif.mc_done) v = hif.mc_data; else st = 1;
      end else if (hif.validE && a == hif.dstE) begin
        if (hif.ismemE) st = 1; else v = hif.rdE;
      end else if (hif.validM && a == hif.dstM) v = hif.rdM;
      f[p*XLEN +: XLEN] = v;
    end
  endtask

  // Check one cycle at the falling edge, then advance the model across the rising edge.
  task automatic step();
    logic st, nb;
    logic [NRD*XLEN-1:0] f;
    logic [AW-1:0] nd;
    logic [31:0] nc;
    @(negedge clk);
    model_comb(st, f);
    chk("stall", hif.stall, st);
    for (int p = 0; p < NRD; p++) chk("fwd", hif.rs_fwd[p*XLEN +: XLEN], f[p*XLEN +: XLEN]);
    chk("busy", hif.mc_busy, m_busy);
    chk("cnt", hif.stall_cnt, m_cnt);
    nb = m_busy; nd = m_dst; nc = m_cnt;
    if (hif.flush) nb = 0;
    else if (hif.issue_mc && !st) begin nb = 1; nd = hif.issue_dst; end
    else if (hif.mc_done && m_busy) nb = 0;
    if (st && !hif.flush && m_cnt != 32'hFFFF_FFFF) nc = m_cnt + 1;
    @(posedge clk); #1;
    m_busy = nb; m_dst = nd; m_cnt = nc;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    m_busy = 0; m_dst = '0; m_cnt = '0;
    reset = 0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", hif.mc_busy, 0);
    chk("rst_cnt", hif.stall_cnt, 0);
    chk("rst_stall", hif.stall, 0);
    reset = 1;

    // load-use
    hif.rs_addr[0 +: AW] = 5; hif.dstE = 5; hif.validE = 1; hif.ismemE = 1;
    #2 chk("lu_stall", hif.stall, 1);
    step();
    chk("lu_cnt", hif.stall_cnt, 1);
    hif.ismemE = 0; hif.rdE = 64'hAA;
    #2 chk("lu_fwd", hif.rs_fwd[0 +: XLEN], 64'hAA);
    chk("lu_nostall", hif.stall, 0);
    step();

    // E over M priority on port 1
    clr();
    hif.rs_addr[AW +: AW] = 7; hif.dstE = 7; hif.dstM = 7; hif.validE = 1; hif.validM = 1;
    hif.rdE = 1; hif.rdM = 2;
    #2 chk("prio_E", hif.rs_fwd[XLEN +: XLEN], 1);
    step();
    hif.validE = 0;
    #2 chk("prio_M", hif.rs_fwd[XLEN +: XLEN], 2);
    step();

    // multi-cycle op to r9
    clr();
    hif.issue_mc = 1; hif.issue_dst = 9;
    step();
    chk("mc_busy", hif.mc_busy, 1);
    clr();
    hif.rs_addr[0 +: AW] = 9; hif.rs_rf[0 +: XLEN] = 64'hDEAD;
    #2 chk("mc_wait", hif.stall, 1);
    step(); step();
    hif.mc_done = 1; hif.mc_data = 64'h1234;
    #2 chk("mc_fwd", hif.rs_fwd[0 +: XLEN], 64'h1234);
    chk("mc_go", hif.stall, 0);
    step();
    chk("mc_free", hif.mc_busy, 0);

    // back-to-back r3 -> r4
    clr();
    hif.issue_mc = 1; hif.issue_dst = 3;
    step();
    hif.issue_dst = 4; hif.mc_done = 1;
    #2 chk("b2b_nostall", hif.stall, 0);
    step();
    clr();
    hif.rs_addr[0 +: AW] = 4;
    #2 chk("b2b_dst4", hif.stall, 1);
    step();
    hif.rs_addr[0 +: AW] = 3;
    #2 chk("b2b_r3free", hif.stall, 0);
    step();

    // flush overrides issue; later mc_done ignored
    hif.flush = 1; hif.issue_mc = 1; hif.issue_dst = 8;
    step();
    chk("fl_busy", hif.mc_busy, 0);
    clr();
    hif.mc_done = 1; hif.mc_data = 64'h55; hif.rs_addr[0 +: AW] = 4; hif.rs_rf[0 +: XLEN] = 64'h77;
    #2 chk("fl_ignore", hif.rs_fwd[0 +: XLEN], 64'h77);
    step();

    // saturation of the stall counter
    clr();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    hif.rs_addr[0 +: AW] = 5; hif.dstE = 5; hif.validE = 1; hif.ismemE = 1;
    step(); step(); step();
    chk("sat", hif.stall_cnt, 32'hFFFF_FFFF);

    // async reset mid-cycle with an op outstanding
    clr();
    hif.issue_mc = 1; hif.issue_dst = 12;
    step();
    clr();
    #2 reset = 0;
    #1 chk("ar_cnt", hif.stall_cnt, 0);
    chk("ar_busy", hif.mc_busy, 0);
    m_busy = 0; m_dst = '0; m_cnt = '0;
    hif.mc_done = 1; hif.mc_data = 64'h99; hif.rs_addr[0 +: AW] = 12; hif.rs_rf[0 +: XLEN] = 64'h42;
    #1 reset = 1;
    step();
    chk("ar_after", hif.mc_busy, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < NRD; p++) begin
        hif.rs_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
        hif.rs_rf[p*XLEN +: XLEN] = {$urandom, $urandom};
      end
      hif.dstE = AW'($urandom_range(0, 7));
      hif.dstM = AW'($urandom_range(0, 7));
      hif.validE = ($urandom_range(0, 1) == 1);
      hif.validM = ($urandom_range(0, 1) == 1);
      hif.ismemE = ($urandom_range(0, 3) == 0);
      hif.rdE = {$urandom, $urandom};
      hif.rdM = {$urandom, $urandom};
      hif.issue_mc = ($urandom_range(0, 9) < 3);
      hif.issue_dst = AW'($urandom_range(0, 7));
      hif.mc_done = ($urandom_range(0, 4) == 0);
      hif.mc_data = {$urandom, $urandom};
      hif.flush = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NRD, default 2, number of operand read ports.
REQ-002 Parameter XLEN, default 64, data width.
REQ-003 Parameter AW, default 5, register address width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rs_addr  input  NRD*AW  per-port source register address; port i occupies bits [i*AW +: AW].
REQ-007 rs_rf  input  NRD*XLEN  per-port register-file read value.
REQ-008 dstE, dstM  input  AW each  destination registers of the Execute and Memory stage instructions.
REQ-009 validE, validM  input  1 each  stage instruction writes its destination.
REQ-010 ismemE  input  1  Execute instruction is a load, so its data is not yet available.
REQ-011 rdE, rdM  input  XLEN each  result values of the Execute and Memory stages.
REQ-012 issue_mc  input  1  decoded instruction is a multi-cycle op (mul/div) that wants to issue this cycle.
REQ-013 issue_dst  input  AW  destination register of that multi-cycle op.
REQ-014 mc_done  input  1  single-cycle pulse from the multi-cycle unit: result valid.
REQ-015 mc_data  input  XLEN  multi-cycle result, valid while mc_done=1.
REQ-016 flush  input  1  pipeline flush; kills the outstanding multi-cycle op.
REQ-017 rs_fwd  output  NRD*XLEN  resolved operand value for each port.
REQ-018 stall  output  1  decode must hold this cycle.
REQ-019 mc_busy  output  1  a multi-cycle op is outstanding (registered).
REQ-020 stall_cnt  output  32  saturating count of stalled cycles.

Function
REQ-021 State: mc_busy, mc_dst (AW bits), stall_cnt; no other storage.
REQ-022 Each port resolves independently, first match wins:
- (a) addr==0 -> value 0, no stall.
- (b) mc_busy and addr==mc_dst: if mc_done, value mc_data; otherwise port stall.
- (c) validE and addr==dstE: if ismemE, port stall; otherwise rdE.
- (d) validM and addr==dstM -> rdM.
- (e) otherwise -> rs_rf.
REQ-023 A port that stalls drives rs_rf as its value.
REQ-024 Structural hazard: issue_mc=1, mc_busy=1 and mc_done=0 -> stall.
REQ-025 stall is the OR of all port stalls and the structural hazard; it is purely combinational with zero-cycle latency.
REQ-026 Issue is accepted when issue_mc=1, stall=0 and flush=0; on acceptance, next cycle mc_busy=1 and mc_dst=issue_dst.
REQ-027 mc_done with mc_busy=1 and no accepted issue -> next cycle mc_busy=0.
REQ-028 mc_done and an accepted issue in the same cycle -> mc_busy stays 1 and mc_dst takes issue_dst (back-to-back ops).
REQ-029 mc_done while mc_busy=0 is ignored: no state change and no forwarding.
REQ-030 flush -> next cycle mc_busy=0; flush overrides a same-cycle issue or mc_done.
REQ-031 Forwarding in the flush cycle follows REQ-022 using the current state.
REQ-032 An issue with issue_dst==0 is accepted and sets mc_busy, but rule (a) prevents any port from stalling on register 0.
REQ-033 stall_cnt increments by 1 on each clk edge where stall=1 and flush=0; it saturates at 0xFFFF_FFFF and never wraps.
REQ-034 All address compares use the full AW bits.
REQ-035 NRD=1 is supported; NRD=0 is not.

Reset
REQ-036 reset=0 asynchronously forces mc_busy=0, mc_dst=0 and stall_cnt=0, independent of clk.
REQ-037 While reset=0, stall=0 unless the combinational inputs cause it.
REQ-038 Deasserting reset while mc_done=1 causes no state change in that cycle.
REQ-039 Reset asserted while an op is outstanding discards it; a later mc_done is ignored per REQ-029.

Verification
REQ-040 Load-use: port0 addr=5, dstE=5, validE=1, ismemE=1 -> stall=1 and stall_cnt +1. Next cycle ismemE=0, rdE=0xAA -> rs_fwd[0]=0xAA, stall=0.
REQ-041 Priority: port1 addr=7, dstE=dstM=7, both valid, rdE=1, rdM=2, ismemE=0 -> rs_fwd[1]=1. With validE=0 -> 2.
REQ-042 Multi-cycle op:
- issue_mc=1, issue_dst=9 accepted -> next cycle mc_busy=1.
- port0 addr=9 -> stall until mc_done=1, mc_data=0x1234 -> same cycle rs_fwd[0]=0x1234, stall=0; next cycle mc_busy=0.
REQ-043 Back-to-back: mc_busy=1, mc_dst=3; issue_mc=1, issue_dst=4 with mc_done=1 -> no stall, next cycle mc_busy=1, mc_dst=4.
REQ-044 Flush: mc_busy=1, flush=1 with issue_mc=1 -> next cycle mc_busy=0. A later mc_done is ignored: port addr=mc_dst reads rs_rf.
REQ-045 Async reset and saturation:
- preload stall_cnt to 0xFFFF_FFFF, hold stall=1 -> count stays 0xFFFF_FFFF.
- pulse reset=0 between clk edges -> stall_cnt=0 and mc_busy=0 immediately.
